// File: rtl/jogo_memoria_param_pkg.sv
// Shared definitions for the parametrised memory game: FSM state codes,
// LFSR feedback mask and small width/step helpers.
package jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARA     = 4'd1,
        EXIBE_ON    = 4'd2,
        EXIBE_OFF   = 4'd3,
        ESPERA      = 4'd4,
        REGISTRA    = 4'd5,
        COMPARA     = 4'd6,
        PROXIMA     = 4'd7,
        ADICIONA    = 4'd8,
        FIM_GANHOU  = 4'd9,
        FIM_PERDEU  = 4'd10,
        FIM_TIMEOUT = 4'd11
    } estado_t;

    // Taps 16/14/13/11 of a right-shifting Fibonacci LFSR sit at bits 0/2/3/5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Bits needed to hold values 0..m-1, never less than one.
    function automatic int largura(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic logic [15:0] lfsr_prox(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/jogo_memoria_param_contador.sv
// Modulo-M counter with synchronous clear, count enable and a terminal flag
// that is only asserted while counting is enabled.
module contador_m
    import jogo_pkg::*;
#(
    parameter int M = 500
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic fim
);

    localparam int W = largura(M);
    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] cnt_reg;

    assign fim = en && (cnt_reg == ULTIMO);

    // Wrapping at the terminal count lets back-to-back phases share one timer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= (cnt_reg == ULTIMO) ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/jogo_memoria_param.sv
// Genius-style memory game controller: shows a growing one-hot sequence,
// checks the player's replay and appends a step from the player or an LFSR.
module jogo_memoria_param
    import jogo_pkg::*;
#(
    parameter int                  N_BOTOES     = 4,
    parameter int                  PROF         = 16,
    parameter int                  RODADAS_DEMO = 4,
    parameter int                  T_EXIBE      = 500,
    parameter int                  T_TIMEOUT    = 3000,
    parameter logic [N_BOTOES-1:0] SEQ0         = 1,
    parameter logic [15:0]         LFSR_SEED    = 16'hACE1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       jogar,
    input  logic [N_BOTOES-1:0]        botoes,
    input  logic [2:0]                 configuracao,
    output logic                       ganhou,
    output logic                       perdeu,
    output logic                       pronto,
    output logic                       timeout,
    output logic [N_BOTOES-1:0]        leds,
    output logic [$clog2(PROF+1)-1:0]  rodada,
    output logic [3:0]                 db_estado
);

    localparam int RW = $clog2(PROF + 1);
    localparam int IW = largura(PROF);
    localparam int SW = largura(N_BOTOES);

    estado_t             estado_reg, estado_next;
    logic [RW-1:0]       rodada_reg, rodada_next;
    logic [IW-1:0]       index_reg, index_next;
    logic [2:0]          cfg_reg, cfg_next;
    logic [N_BOTOES-1:0] press_reg, press_next;
    logic [15:0]         lfsr_reg;
    logic                jogar_prev_reg;
    logic                botoes_prev_reg;

    logic [N_BOTOES-1:0] seq [PROF];
    logic                wr_en;
    logic [IW-1:0]       wr_addr;
    logic [N_BOTOES-1:0] wr_data;

    logic disp_clr, disp_en, disp_fim;
    logic tmo_clr, tmo_en, tmo_fim;

    logic          jogar_sobe;
    logic          press;
    logic          ultimo_idx;
    logic [RW-1:0] limite;

    function automatic logic um_quente(input logic [N_BOTOES-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    assign jogar_sobe = jogar && !jogar_prev_reg;
    assign press      = (|botoes) && !botoes_prev_reg;
    assign ultimo_idx = (RW'(index_reg) == (rodada_reg - RW'(1)));
    assign limite     = cfg_reg[0] ? RW'(RODADAS_DEMO) : RW'(PROF);

    contador_m #(.M(T_EXIBE)) u_disp (
        .clock (clock),
        .reset (reset),
        .clr   (disp_clr),
        .en    (disp_en),
        .fim   (disp_fim)
    );

    contador_m #(.M(T_TIMEOUT)) u_tmo (
        .clock (clock),
        .reset (reset),
        .clr   (tmo_clr),
        .en    (tmo_en),
        .fim   (tmo_fim)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_reg      <= INICIAL;
            rodada_reg      <= '0;
            index_reg       <= '0;
            cfg_reg         <= '0;
            press_reg       <= '0;
            jogar_prev_reg  <= 1'b0;
            botoes_prev_reg <= 1'b0;
            lfsr_reg        <= LFSR_SEED;
        end else begin
            estado_reg      <= estado_next;
            rodada_reg      <= rodada_next;
            index_reg       <= index_next;
            cfg_reg         <= cfg_next;
            press_reg       <= press_next;
            jogar_prev_reg  <= jogar;
            botoes_prev_reg <= |botoes;
            lfsr_reg        <= lfsr_prox(lfsr_reg);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PROF; i++) begin
                seq[i] <= (i == 0) ? SEQ0 : '0;
            end
        end else if (wr_en) begin
            seq[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        estado_next = estado_reg;
        rodada_next = rodada_reg;
        index_next  = index_reg;
        cfg_next    = cfg_reg;
        press_next  = press_reg;
        wr_en       = 1'b0;
        wr_addr     = IW'(rodada_reg);
        wr_data     = botoes;
        disp_clr    = 1'b1;
        disp_en     = 1'b0;
        tmo_clr     = 1'b1;
        tmo_en      = 1'b0;

        case (estado_reg)
            INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
                if (jogar_sobe) begin
                    cfg_next    = configuracao;
                    estado_next = PREPARA;
                end
            end
            PREPARA: begin
                wr_en       = 1'b1;
                wr_addr     = '0;
                wr_data     = SEQ0;
                rodada_next = RW'(1);
                index_next  = '0;
                estado_next = EXIBE_ON;
            end
            EXIBE_ON: begin
                disp_clr = 1'b0;
                disp_en  = 1'b1;
                if (disp_fim) begin
                    estado_next = EXIBE_OFF;
                end
            end
            EXIBE_OFF: begin
                disp_clr = 1'b0;
                disp_en  = 1'b1;
                if (disp_fim) begin
                    if (ultimo_idx) begin
                        index_next  = '0;
                        estado_next = ESPERA;
                    end else begin
                        index_next  = index_reg + 1'b1;
                        estado_next = EXIBE_ON;
                    end
                end
            end
            ESPERA: begin
                // A press restarts the idle window and beats a coincident timeout.
                tmo_clr = press;
                tmo_en  = 1'b1;
                if (press) begin
                    press_next  = botoes;
                    estado_next = REGISTRA;
                end else if (cfg_reg[1] && tmo_fim) begin
                    estado_next = FIM_TIMEOUT;
                end
            end
            REGISTRA: begin
                estado_next = COMPARA;
            end
            COMPARA: begin
                // seq only ever holds one-hot values, so multi-button presses fail here.
                if (press_reg != seq[index_reg]) begin
                    estado_next = FIM_PERDEU;
                end else if (ultimo_idx) begin
                    estado_next = PROXIMA;
                end else begin
                    index_next  = index_reg + 1'b1;
                    estado_next = ESPERA;
                end
            end
            PROXIMA: begin
                if (rodada_reg == limite) begin
                    estado_next = FIM_GANHOU;
                end else if (cfg_reg[2]) begin
                    wr_en       = 1'b1;
                    wr_data     = N_BOTOES'(1) << lfsr_reg[SW-1:0];
                    rodada_next = rodada_reg + 1'b1;
                    index_next  = '0;
                    estado_next = EXIBE_ON;
                end else begin
                    estado_next = ADICIONA;
                end
            end
            ADICIONA: begin
                tmo_clr = press;
                tmo_en  = 1'b1;
                if (press && um_quente(botoes)) begin
                    wr_en       = 1'b1;
                    rodada_next = rodada_reg + 1'b1;
                    index_next  = '0;
                    estado_next = EXIBE_ON;
                end else if (!press && cfg_reg[1] && tmo_fim) begin
                    estado_next = FIM_TIMEOUT;
                end
            end
            default: begin
                estado_next = INICIAL;
            end
        endcase
    end

    assign ganhou    = (estado_reg == FIM_GANHOU);
    assign perdeu    = (estado_reg == FIM_PERDEU) || (estado_reg == FIM_TIMEOUT);
    assign timeout   = (estado_reg == FIM_TIMEOUT);
    assign pronto    = ganhou || perdeu;
    assign leds      = (estado_reg == EXIBE_ON) ? seq[index_reg] : '0;
    assign rodada    = rodada_reg;
    assign db_estado = estado_reg;

endmodule
